// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM status and responder state types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DACC = 3'd1,
        IACC = 3'd2,
        DHIT = 3'd3,
        IHIT = 3'd4
    } memresp_state_t;

endpackage

// File: rtl/memory_responder.sv
// memory_responder: arbitrates instruction/data requests onto one RAM port and returns hits
// Ports: CLK/RST (async active-high); iREN/iaddr instruction read; dREN/dWEN/daddr/dstore
// data access; ihit/iload, dhit/dload one-cycle hits with registered words; err sticky
// RAM-error/timeout flag; ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate RAM port.
module memory_responder
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      err,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int CW = $clog2(TIMEOUT + 1);

    memresp_state_t state_q, state_d;
    logic           last_d_q, last_d_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    word_t          iload_q, iload_d, dload_q, dload_d;
    logic           dreq, in_acc, req_held, tmo;

    always_comb begin
        dreq     = dREN | dWEN;
        in_acc   = state_q == DACC || state_q == IACC;
        req_held = state_q == DACC ? dreq : iREN;
        // Limits an access to TIMEOUT cycles; ACCESS is checked first so it wins on the last one.
        tmo      = 32'(cnt_q) + 32'd1 >= 32'(TIMEOUT);
        state_d  = state_q;
        last_d_d = last_d_q;
        err_d    = err_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        cnt_d    = in_acc && cnt_q != CW'(TIMEOUT) ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            IDLE: begin
                // Data has priority except right after a data grant, so neither side starves.
                if (dreq && (!iREN || !last_d_q)) begin
                    state_d  = DACC;
                    last_d_d = 1'b1;
                    cnt_d    = '0;
                end else if (iREN) begin
                    state_d  = IACC;
                    last_d_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            DACC, IACC: begin
                if (!req_held) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = state_q == DACC ? DHIT : IHIT;
                    if (state_q == IACC) iload_d = ramload;
                    else if (!dWEN) dload_d = ramload;
                end else if (ramstate == ERROR || tmo) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
        end
    end

    // A simultaneous read+write request is served as a write only.
    assign ramWEN   = state_q == DACC && dWEN;
    assign ramREN   = (state_q == DACC && !dWEN) || state_q == IACC;
    assign ramaddr  = state_q == DACC ? daddr : state_q == IACC ? iaddr : '0;
    assign ramstore = ramWEN ? dstore : '0;
    assign ihit     = state_q == IHIT;
    assign dhit     = state_q == DHIT;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign err      = err_q;

endmodule

// File: doc/memory_responder.md
# memory_responder

Memory-side responder for the core's instruction and data request handshake. It accepts level-held instruction reads and data reads or writes, and arbitrates them onto a single RAM port. It returns a one-cycle `ihit` or `dhit` with the load word. It sits between the datapath's request logic and the shared RAM, and it is the counterpart that produces the hits the request logic waits on.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum cycles spent waiting in an access state before the access is abandoned.

Ports:
- `CLK`, in, 1: the single clock.
- `RST`, in, 1: reset, asynchronous, active-high.
- `iREN`, in, 1: instruction read request, held high until `ihit`.
- `iaddr`, in, 32 (`word_t`): instruction address.
- `dREN`, in, 1: data read request, held high until `dhit`.
- `dWEN`, in, 1: data write request, held high until `dhit`.
- `daddr`, in, 32: data address.
- `dstore`, in, 32: data write word.
- `ihit`, out, 1: one-cycle pulse; `iload` is valid in this cycle.
- `iload`, out, 32: registered instruction word.
- `dhit`, out, 1: one-cycle pulse; completes a data read or write.
- `dload`, out, 32: registered data read word.
- `err`, out, 1: sticky flag; set on a RAM error or a timeout.
- `ramREN`, out, 1: RAM read enable.
- `ramWEN`, out, 1: RAM write enable.
- `ramaddr`, out, 32: RAM address.
- `ramstore`, out, 32: RAM write data.
- `ramload`, in, 32: RAM read data.
- `ramstate`, in, 2 (`ramstate_t`): RAM status, one of FREE, BUSY, ACCESS or ERROR.

## Operation
- The FSM has five states: IDLE, DACC, IACC, DHIT and IHIT.
- **IDLE arbitration:**
  - If a data request (`dREN|dWEN`) and `iREN` are both pending, data wins, unless the previous grant was data. In that case instruction wins once.
  - A `last_d` register tracks this; it is set on every DACC entry and cleared on every IACC entry.
  - If only one request is pending, that request is granted.
  - If no request is pending, the FSM stays in IDLE.
- **DACC:**
  - Drives `ramaddr=daddr`.
  - If `dWEN` is high: drives `ramWEN=1` and `ramstore=dstore`.
  - Otherwise: drives `ramREN=1`.
  - If `dREN` and `dWEN` are both high, the access is a write only.
- **IACC:** drives `ramREN=1` and `ramaddr=iaddr`. `ramWEN` stays 0.
- **In IDLE, DHIT and IHIT:** `ramREN=ramWEN=0`, and `ramaddr` and `ramstore` are 0.
- **Exits from DACC and IACC:**
  - `ramstate==ACCESS`: latch `ramload` into `dload` or `iload` (reads only; a write leaves `dload` unchanged), then go to DHIT or IHIT.
  - `ramstate==ERROR`: set `err`, go to IDLE, no hit.
  - Wait counter reaches `TIMEOUT`: set `err`, go to IDLE, no hit.
  - Request dropped mid-access (DACC with `dREN=dWEN=0`, or IACC with `iREN=0`): abort to IDLE, no hit, `err` unchanged.
- **DHIT and IHIT:**
  - `dhit` or `ihit` is 1 for exactly this cycle.
  - The next state is always IDLE. This gives the requester one cycle to deassert its enables before they are sampled again.
- **Wait counter:**
  - Width is `$clog2(TIMEOUT+1)`.
  - Cleared on entry to DACC or IACC; increments each cycle while in DACC or IACC.
  - Saturates; it never wraps.
- `err` is cleared only by `RST`.

## Timing
- **Reset:** state IDLE, `last_d=0`, counter 0. All outputs are 0: `ihit`, `dhit`, `iload`, `dload`, `err` and all `ram*` outputs.
- **`RST` asserted mid-access:** the FSM goes to IDLE immediately (asynchronous) and no hit is generated. After release, a request still held high is re-arbitrated from IDLE.
- **Minimum latency:**
  - Request sampled in IDLE at cycle 0.
  - Access state in cycle 1; RAM returns ACCESS in cycle 1.
  - Hit in cycle 2.
- **General latency:** hit arrives 2 + n cycles after the request, where n is the number of BUSY or FREE cycles before ACCESS.
- **Back-to-back:** the minimum spacing between hits is 3 cycles (hit, IDLE, access).
- **Hit outputs:** `ihit` and `dhit` are state-decoded and never high together. `iload` and `dload` hold their value until the next successful read of the same kind.
- **Late ACCESS vs timeout:** if ACCESS arrives in the same cycle the counter reaches `TIMEOUT`, ACCESS wins.

## Structure
- `ramstate_t` (FREE=0, BUSY=1, ACCESS=2, ERROR=3) and `word_t` come from `cpu_types_pkg`.
- Add `memresp_state_t` to `cpu_types_pkg` so that traces decode it.
- Single module, no sub-modules. The arbiter fairness logic is inline.

## Test plan
- **Single instruction read:** `iREN=1`, `iaddr=0x40`; RAM returns ACCESS in the first IACC cycle with `ramload=0x2001000A`. Required: `ihit` in cycle 2, `iload=0x2001000A`, `ramREN=1` only in cycle 1.
- **Data write with wait states:** `dWEN=1`, `daddr=0x80`, `dstore=0xDEADBEEF`; RAM returns BUSY×3 then ACCESS. Required: `ramWEN=1` and `ramstore=0xDEADBEEF` for 4 cycles, then `dhit` in cycle 5, `dload` unchanged.
- **Simultaneous requests:** `iREN` and `dREN` both held. Required grants alternate D, I, D, I; no request waits for more than one other hit.
- **RAM error:** `dREN=1` with `ramstate=ERROR` in DACC. Required: no `dhit`, `err=1`, which persists through later successful accesses until `RST`.
- **Timeout:** `TIMEOUT=4`, `ramstate` stuck at BUSY. Required: `err` is set at the 4th wait cycle, the FSM returns to IDLE, and no hit occurs.
- **Abort and reset:**
  - `iREN` dropped during IACC. Required: return to IDLE with no hit.
  - `RST` pulsed during DACC. Required: all outputs are 0 immediately, and the held request completes normally after release.
